// File: rtl/sample_streamer.sv
// sample_streamer: buffered sample playback source.
// Samples are written into an internal buffer, then replayed in order on
// `data`, one sample per `enable` strobe, paced by the sink's `ready`.
// Optional feature macro: SAMPLE_STREAMER_LOOP_EN (continuous looped playback
// with a one-cycle `done` pulse per pass; stop ends playback).

module sample_streamer #(
    parameter int DATA_WIDTH = 7,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH:0]   wr_data,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  ready,
    output logic [DATA_WIDTH:0]   data,
    output logic                  enable,
    output logic                  done,
    output logic                  full,
    output logic [ADDR_WIDTH:0]   fill
);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH:0] DEPTH_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE         = (ADDR_WIDTH + 1)'(1);

    // Sample storage; contents are not reset, only the fill count is.
    logic [DATA_WIDTH:0] mem [DEPTH];

    state_t              state, state_next;
    logic [ADDR_WIDTH:0] fill_next;
    logic [ADDR_WIDTH:0] rd_ptr, rd_ptr_next;
    logic [DATA_WIDTH:0] data_next;
    logic                enable_next;
    logic                done_next;
    logic                mem_we;

    assign full = (fill == DEPTH_COUNT);

    // Next-state and next-output logic; loading, clear and start are only honoured outside STREAM.
    always_comb begin
        state_next  = state;
        fill_next   = fill;
        rd_ptr_next = rd_ptr;
        data_next   = data;
        enable_next = 1'b0;
        done_next   = done;
        mem_we      = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (clear) begin
                    fill_next  = '0;
                    done_next  = 1'b0;
                    state_next = IDLE;
                end else if (wr_en) begin
                    if (!full) begin
                        mem_we    = 1'b1;
                        fill_next = fill + ONE;
                    end
                end else if (start && (fill != '0)) begin
                    rd_ptr_next = '0;
                    done_next   = 1'b0;
                    state_next  = STREAM;
                end
            end

            STREAM: begin
`ifdef SAMPLE_STREAMER_LOOP_EN
                done_next = 1'b0;
`endif
                if (stop) begin
                    state_next = DONE;
                    done_next  = 1'b1;
                end else if (ready) begin
                    data_next   = mem[rd_ptr[ADDR_WIDTH-1:0]];
                    enable_next = 1'b1;
                    if (rd_ptr == (fill - ONE)) begin
`ifdef SAMPLE_STREAMER_LOOP_EN
                        rd_ptr_next = '0;
                        done_next   = 1'b1;
`else
                        rd_ptr_next = rd_ptr + ONE;
                        state_next  = DONE;
                        done_next   = 1'b1;
`endif
                    end else begin
                        rd_ptr_next = rd_ptr + ONE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, pointer, fill count and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            fill   <= '0;
            rd_ptr <= '0;
            data   <= '0;
            enable <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_next;
            fill   <= fill_next;
            rd_ptr <= rd_ptr_next;
            data   <= data_next;
            enable <= enable_next;
            done   <= done_next;
        end
    end

    // Buffer write at the current fill position.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[fill[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

endmodule

// File: tb/tb_sample_streamer.sv
// Testbench for sample_streamer: scenario tasks compared cycle by cycle
// against a queue-based reference model of the playback rules.
// Optional feature macro: SAMPLE_STREAMER_LOOP_EN (enables the loop scenario).

module tb_sample_streamer;

    localparam int DW    = 7;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    typedef struct packed {
        logic          w;
        logic [DW:0]   wd;
        logic          c;
        logic          s;
        logic          p;
        logic          r;
    } stim_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [DW:0]   wr_data;
    logic          clear;
    logic          start;
    logic          stop;
    logic          ready;
    logic [DW:0]   data;
    logic          enable;
    logic          done;
    logic          full;
    logic [AW:0]   fill;

    int checks = 0;
    int errors = 0;

    // Reference model state: loaded samples, playback position and outputs.
    logic [DW:0]   m_buf[$];
    bit            m_play;
    int            m_idx;
    bit            m_done;
    logic [DW:0]   m_data;
    bit            m_en;

    sample_streamer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .clear   (clear),
        .start   (start),
        .stop    (stop),
        .ready   (ready),
        .data    (data),
        .enable  (enable),
        .done    (done),
        .full    (full),
        .fill    (fill)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    function automatic stim_t mk(logic w, logic [DW:0] wd, logic c, logic s, logic p, logic r);
        stim_t st;
        st.w = w; st.wd = wd; st.c = c; st.s = s; st.p = p; st.r = r;
        return st;
    endfunction

    function automatic logic [DW+AW+4:0] exp_vec();
        return {m_data, m_en, m_done, (m_buf.size() == DEPTH), (AW + 1)'(m_buf.size())};
    endfunction

    function automatic logic [DW+AW+4:0] act_vec();
        return {data, enable, done, full, fill};
    endfunction

    function automatic void model_reset();
        m_buf.delete();
        m_play = 0;
        m_idx  = 0;
        m_done = 0;
        m_data = '0;
        m_en   = 0;
    endfunction

    // Applies the playback rules for one clock edge with the given inputs.
    function automatic void model_edge(stim_t st);
        m_en = 0;
        if (!m_play) begin
            if (st.c) begin
                m_buf.delete();
                m_done = 0;
            end else if (st.w) begin
                if (m_buf.size() < DEPTH) m_buf.push_back(st.wd);
            end else if (st.s && m_buf.size() > 0) begin
                m_play = 1;
                m_idx  = 0;
                m_done = 0;
            end
        end else begin
`ifdef SAMPLE_STREAMER_LOOP_EN
            m_done = 0;
`endif
            if (st.p) begin
                m_play = 0;
                m_done = 1;
            end else if (st.r) begin
                m_data = m_buf[m_idx];
                m_en   = 1;
                m_idx++;
                if (m_idx == m_buf.size()) begin
                    m_done = 1;
`ifdef SAMPLE_STREAMER_LOOP_EN
                    m_idx = 0;
`else
                    m_play = 0;
`endif
                end
            end
        end
    endfunction

    // Drives one cycle of inputs, advances the model at the edge, returns 1 ns after it.
    task automatic drive_cycle(input stim_t st);
        wr_en   = st.w;
        wr_data = st.wd;
        clear   = st.c;
        start   = st.s;
        stop    = st.p;
        ready   = st.r;
        @(posedge clk);
        model_edge(st);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (act_vec() !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state: got %h expected %h", act_vec(), '0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive_cycle(mk(0, 0, 0, 0, 0, 0));
        checks++;
        if (act_vec() !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL reset_release: got %h expected %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_basic();
        stim_t q[$];
        logic [DW:0] seen[$];
        q.push_back(mk(0, 0, 1, 0, 0, 0));
        q.push_back(mk(1, 8'h11, 0, 0, 0, 0));
        q.push_back(mk(1, 8'h22, 0, 0, 0, 0));
        q.push_back(mk(1, 8'h33, 0, 0, 0, 0));
        q.push_back(mk(0, 0, 0, 1, 0, 0));
        for (int i = 0; i < 5; i++) q.push_back(mk(0, 0, 0, 0, 0, 1));
        foreach (q[i]) begin
            drive_cycle(q[i]);
            if (enable) seen.push_back(data);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL basic cycle %0d: got %h expected %h", i, act_vec(), exp_vec());
            end
        end
        checks++;
        if (seen.size() != 3 || seen[0] !== 8'h11 || seen[1] !== 8'h22 || seen[2] !== 8'h33) begin
            errors++;
            $display("[TB] FAIL basic_sequence: got %0d strobes expected 3 (11,22,33)", seen.size());
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_done: got %b expected 1", done);
        end
    endtask

    task automatic test_backpressure();
        stim_t q[$];
        logic r_pat[7] = '{1, 0, 0, 1, 1, 0, 0};
        int n = 0;
        q.push_back(mk(0, 0, 1, 0, 0, 0));
        q.push_back(mk(1, 8'h11, 0, 0, 0, 0));
        q.push_back(mk(1, 8'h22, 0, 0, 0, 0));
        q.push_back(mk(1, 8'h33, 0, 0, 0, 0));
        q.push_back(mk(0, 0, 0, 1, 0, 0));
        foreach (r_pat[i]) q.push_back(mk(0, 0, 0, 0, 0, r_pat[i]));
        foreach (q[i]) begin
            drive_cycle(q[i]);
            if (enable) n++;
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL backpressure cycle %0d: got %h expected %h", i, act_vec(), exp_vec());
            end
        end
        checks++;
        if (n != 3) begin
            errors++;
            $display("[TB] FAIL backpressure_strobes: got %0d expected 3", n);
        end
    endtask

    task automatic test_full();
        logic [DW:0] wr[17];
        logic [DW:0] last = '0;
        int n = 0;
        drive_cycle(mk(0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 17; i++) begin
            wr[i] = DW'($urandom) ^ 8'h80;
            drive_cycle(mk(1, wr[i], 0, 0, 0, 0));
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL full_load %0d: got %h expected %h", i, act_vec(), exp_vec());
            end
        end
        checks++;
        if (fill !== 5'd16 || full !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_flag: got fill=%0d full=%b expected fill=16 full=1", fill, full);
        end
        drive_cycle(mk(0, 0, 0, 1, 0, 0));
        for (int i = 0; i < 18; i++) begin
            drive_cycle(mk(0, 0, 0, 0, 0, 1));
            if (enable) begin n++; last = data; end
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL full_play %0d: got %h expected %h", i, act_vec(), exp_vec());
            end
        end
        checks++;
        if (n != 16 || last !== wr[15]) begin
            errors++;
            $display("[TB] FAIL full_last: got %0d strobes last=%h expected 16 last=%h", n, last, wr[15]);
        end
    endtask

    task automatic test_stop_restart();
        stim_t q[$];
        int n = 0;
        q.push_back(mk(0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 5; i++) q.push_back(mk(1, DW'($urandom), 0, 0, 0, 0));
        q.push_back(mk(0, 0, 0, 1, 0, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 1));
        q.push_back(mk(0, 0, 0, 0, 0, 1));
        q.push_back(mk(0, 0, 0, 0, 1, 1));
        q.push_back(mk(0, 0, 0, 0, 0, 1));
        q.push_back(mk(0, 0, 0, 0, 0, 1));
        q.push_back(mk(0, 0, 0, 1, 0, 1));
        for (int i = 0; i < 7; i++) q.push_back(mk(0, 0, 0, 0, 0, 1));
        foreach (q[i]) begin
            drive_cycle(q[i]);
            if (enable) n++;
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL stop_restart cycle %0d: got %h expected %h", i, act_vec(), exp_vec());
            end
        end
        checks++;
        if (n != 7) begin
            errors++;
            $display("[TB] FAIL stop_restart_strobes: got %0d expected 7", n);
        end
    endtask

    task automatic test_reset_mid_stream();
        stim_t q[$];
        q.push_back(mk(0, 0, 1, 0, 0, 0));
        for (int i = 0; i < 4; i++) q.push_back(mk(1, DW'($urandom), 0, 0, 0, 0));
        q.push_back(mk(0, 0, 0, 1, 0, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 1));
        q.push_back(mk(0, 0, 0, 0, 0, 1));
        foreach (q[i]) drive_cycle(q[i]);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (act_vec() !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid_stream: got %h expected %h", act_vec(), '0);
        end
        #1 rst_n = 1'b1;
        drive_cycle(mk(0, 0, 0, 1, 0, 1));
        for (int i = 0; i < 4; i++) begin
            drive_cycle(mk(0, 0, 0, 0, 0, 1));
            checks++;
            if (act_vec() !== exp_vec() || enable !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_then_start %0d: got %h expected %h", i, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive_cycle(mk(($urandom % 3) == 0, DW'($urandom), ($urandom % 40) == 0,
                           ($urandom % 6) == 0, ($urandom % 25) == 0, ($urandom % 2) == 0));
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL random cycle %0d: got %h expected %h", i, act_vec(), exp_vec());
            end
        end
    endtask

`ifdef SAMPLE_STREAMER_LOOP_EN
    task automatic test_loop();
        logic [DW:0] exp_d[6] = '{8'hA0, 8'hA1, 8'hA0, 8'hA1, 8'hA0, 8'hA1};
        drive_cycle(mk(0, 0, 1, 0, 0, 0));
        drive_cycle(mk(1, 8'hA0, 0, 0, 0, 0));
        drive_cycle(mk(1, 8'hA1, 0, 0, 0, 0));
        drive_cycle(mk(0, 0, 0, 1, 0, 0));
        for (int i = 0; i < 6; i++) begin
            drive_cycle(mk(0, 0, 0, 0, 0, 1));
            checks++;
            if (act_vec() !== exp_vec() || data !== exp_d[i] || done !== logic'(i % 2)) begin
                errors++;
                $display("[TB] FAIL loop strobe %0d: got %h expected %h", i, act_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive_cycle(mk(0, 0, 0, 0, i == 0, 1));
            checks++;
            if (act_vec() !== exp_vec() || done !== 1'b1) begin
                errors++;
                $display("[TB] FAIL loop_stop %0d: got %h expected %h", i, act_vec(), exp_vec());
            end
        end
    endtask
`endif

    // Runs every scenario in sequence, then prints the summary.
    initial begin
        wr_en   = 1'b0;
        wr_data = '0;
        clear   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        ready   = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_backpressure();
        test_full();
        test_stop_restart();
        test_reset_mid_stream();
`ifdef SAMPLE_STREAMER_LOOP_EN
        test_loop();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
